// File: rtl/fine_delay_pkg.sv
// Shared types and default constants for the MMCM fine-phase step sequencer.
package fine_delay_pkg;

  localparam int unsigned DEF_STEPS_PER_PERIOD = 497;
  localparam int unsigned DEF_PS_TIMEOUT       = 63;
  localparam int unsigned StepW                = 9;
  localparam int unsigned ArithW               = 10;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StIssue,
    StWait
  } state_e;

endpackage

// File: rtl/ps_step_sequencer_if.sv
// Request handshake carrying a new absolute phase target into the sequencer.
interface ps_step_sequencer_if;
  import fine_delay_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [StepW-1:0] req_target;

  modport master (output req_valid, output req_target, input req_ready);
  modport slave  (input req_valid, input req_target, output req_ready);

endinterface

// File: rtl/ps_wrap_dist.sv
// Forward distance from cur_steps to target modulo the period, plus shortest direction.
module ps_wrap_dist
  import fine_delay_pkg::*;
#(
  parameter int unsigned STEPS_PER_PERIOD = DEF_STEPS_PER_PERIOD
) (
  input  logic [StepW-1:0]  cur_steps,
  input  logic [StepW-1:0]  target,
  output logic [ArithW-1:0] dist_up,
  output logic              incdec
);

  localparam logic [ArithW-1:0] Steps = ArithW'(STEPS_PER_PERIOD);
  localparam logic [ArithW-1:0] Half  = ArithW'(STEPS_PER_PERIOD / 2);

  logic [ArithW-1:0] raw;

  // Adding the period first keeps the difference non-negative; one subtract folds it back.
  always_comb begin
    raw     = {1'b0, target} + Steps - {1'b0, cur_steps};
    dist_up = (raw >= Steps) ? raw - Steps : raw;
    incdec  = (dist_up <= Half);
  end

endmodule

// File: rtl/ps_step_sequencer.sv
// Walks the MMCM fine phase one PSEN step at a time to an absolute target position.
module ps_step_sequencer
  import fine_delay_pkg::*;
#(
  parameter int unsigned STEPS_PER_PERIOD = DEF_STEPS_PER_PERIOD,
  parameter int unsigned PS_TIMEOUT       = DEF_PS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  ps_step_sequencer_if.slave req,
  input  logic              mmcm_locked,
  output logic              ps_en,
  output logic              ps_incdec,
  input  logic              ps_done,
  output logic [StepW-1:0]  cur_steps,
  output logic              busy,
  output logic              done_pulse,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              err_range,
  output logic              err_lock
);

  localparam logic [ArithW-1:0] Steps   = ArithW'(STEPS_PER_PERIOD);
  localparam logic [StepW-1:0]  LastPos = StepW'(STEPS_PER_PERIOD - 1);
  localparam int unsigned       TmoW    = (PS_TIMEOUT > 1) ? $clog2(PS_TIMEOUT) : 1;
  localparam logic [TmoW-1:0]   TmoLast = TmoW'(PS_TIMEOUT - 1);

  state_e            state;
  logic [StepW-1:0]  target;
  logic [TmoW-1:0]   tmo_cnt;
  logic [ArithW-1:0] dist_up;
  logic              dir_inc;
  logic [StepW-1:0]  pos_up;
  logic [StepW-1:0]  pos_dn;

  ps_wrap_dist #(
    .STEPS_PER_PERIOD(STEPS_PER_PERIOD)
  ) u_wrap_dist (
    .cur_steps(cur_steps),
    .target   (target),
    .dist_up  (dist_up),
    .incdec   (dir_inc)
  );

  assign pos_up        = (cur_steps == LastPos) ? '0 : cur_steps + 1'b1;
  assign pos_dn        = (cur_steps == '0) ? LastPos : cur_steps - 1'b1;
  assign req.req_ready = (state == StIdle) && mmcm_locked;
  assign busy          = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      target      <= '0;
      tmo_cnt     <= '0;
      cur_steps   <= '0;
      ps_en       <= 1'b0;
      ps_incdec   <= 1'b0;
      done_pulse  <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      err_lock    <= 1'b0;
    end else begin
      ps_en      <= 1'b0;
      done_pulse <= 1'b0;
      // Clear first so an error raised below in the same cycle wins.
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_range   <= 1'b0;
        err_lock    <= 1'b0;
      end
      if (!mmcm_locked) begin
        // MMCM reset puts the phase back at 0.
        state     <= StIdle;
        cur_steps <= '0;
        if ((state != StIdle) || (cur_steps != '0)) err_lock <= 1'b1;
      end else begin
        unique case (state)
          StIdle: begin
            if (req.req_valid) begin
              if ({1'b0, req.req_target} >= Steps) begin
                err_range <= 1'b1;
              end else begin
                target <= req.req_target;
                state  <= StEval;
              end
            end
          end
          StEval: begin
            if (dist_up == '0) begin
              done_pulse <= 1'b1;
              state      <= StIdle;
            end else begin
              // ps_en is registered here so it is high exactly during the ISSUE cycle.
              ps_incdec <= dir_inc;
              ps_en     <= 1'b1;
              state     <= StIssue;
            end
          end
          StIssue: begin
            tmo_cnt <= '0;
            state   <= StWait;
          end
          StWait: begin
            if (ps_done) begin
              cur_steps <= ps_incdec ? pos_up : pos_dn;
              state     <= StEval;
            end else if (tmo_cnt == TmoLast) begin
              err_timeout <= 1'b1;
              state       <= StIdle;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps_step_sequencer.sv
// Scoreboard bench: stimulus queues expected ps_en/done_pulse events, a monitor checks them.
module tb_ps_step_sequencer;

  localparam int N    = 497;
  localparam int HALF = 248;

  typedef struct packed {
    logic       is_done;
    logic       incdec;
    logic [8:0] cur;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mmcm_locked = 1'b1;
  logic       ps_en, ps_incdec, busy, done_pulse;
  logic       ps_done = 1'b0;
  logic [8:0] cur_steps;
  logic       err_clr = 1'b0;
  logic       err_timeout, err_range, err_lock;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_cur = 0;
  int  ps_delay = 12;
  int  pend = 0;
  bit  silent = 1'b0;
  bit  force_done = 1'b0;
  ev_t exp_q[$];

  ps_step_sequencer_if req_if ();

  ps_step_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req_if.slave),
    .mmcm_locked(mmcm_locked),
    .ps_en      (ps_en),
    .ps_incdec  (ps_incdec),
    .ps_done    (ps_done),
    .cur_steps  (cur_steps),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_clr    (err_clr),
    .err_timeout(err_timeout),
    .err_range  (err_range),
    .err_lock   (err_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // PSDONE model: one-cycle pulse ps_delay cycles after each ps_en unless silent.
  initial forever begin
    @(negedge clk);
    ps_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) ps_done = 1'b1;
    end
    if (force_done) ps_done = 1'b1;
    if (ps_en && !silent) pend = ps_delay;
  end

  // Monitor / scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ps_en || done_pulse)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got ps_en=%0b done_pulse=%0b cur=%0d, required none",
                   ps_en, done_pulse, cur_steps);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_done", int'(done_pulse), int'(e.is_done));
          if (!e.is_done) check("step_incdec", int'(ps_incdec), int'(e.incdec));
          check("event_cur", int'(cur_steps), int'(e.cur));
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push_ev(input bit is_done, input bit inc, input int cur);
    ev_t e;
    e.is_done = is_done;
    e.incdec  = inc;
    e.cur     = 9'(cur);
    exp_q.push_back(e);
  endtask

  task automatic push_move(input int tgt);
    int c = m_cur;
    int d;
    bit inc;
    while (c != tgt) begin
      d   = (tgt + N - c) % N;
      inc = (d <= HALF);
      push_ev(1'b0, inc, c);
      if (inc) c = (c == N - 1) ? 0 : c + 1;
      else     c = (c == 0) ? N - 1 : c - 1;
    end
    push_ev(1'b1, 1'b0, tgt);
    m_cur = tgt;
  endtask

  // Ends on the negedge right after the accepting posedge.
  task automatic send(input int tgt, input bit clr);
    @(negedge clk);
    req_if.req_valid  = 1'b1;
    req_if.req_target = 9'(tgt);
    err_clr           = clr;
    @(negedge clk);
    req_if.req_valid  = 1'b0;
    err_clr           = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({nm, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic do_move(input int tgt);
    push_move(tgt);
    send(tgt, 1'b0);
    wait_idle("move", 8000);
    check("cur_after_move", int'(cur_steps), tgt);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int n;
    req_if.req_valid  = 1'b0;
    req_if.req_target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cur", int'(cur_steps), 0);
    check("rst_ps_en", int'(ps_en), 0);
    check("rst_incdec", int'(ps_incdec), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_errs", int'({err_timeout, err_range, err_lock}), 0);
    check("rst_ready", int'(req_if.req_ready), 1);

    // 0 -> 5, slow PSDONE.
    ps_delay = 12;
    do_move(5);

    // No move needed: done_pulse two cycles after the accept cycle.
    push_ev(1'b1, 1'b0, 5);
    send(5, 1'b0);
    check("nomove_busy", int'(busy), 1);
    check("nomove_done_early", int'(done_pulse), 0);
    @(negedge clk);
    check("nomove_done", int'(done_pulse), 1);
    wait_idle("nomove", 20);

    // Downward wrap 2 -> 495, then upward wrap 495 -> 0.
    ps_delay = 3;
    do_move(2);
    do_move(495);
    ps_delay = 1;
    do_move(0);

    // Half-period tie-break.
    do_move(248);
    do_move(0);
    do_move(249);

    // Out-of-range targets.
    send(497, 1'b0);
    check("range_err", int'(err_range), 1);
    check("range_ready", int'(req_if.req_ready), 1);
    check("range_busy", int'(busy), 0);
    pulse_clr();
    check("range_clr", int'(err_range), 0);
    send(511, 1'b1);
    check("range_clr_vs_set", int'(err_range), 1);
    pulse_clr();
    check("range_cur", int'(cur_steps), 249);

    // Silent PSDONE: timeout after 63 WAIT cycles.
    silent = 1'b1;
    push_ev(1'b0, 1'b1, 249);
    send(250, 1'b0);
    n = 0;
    for (int i = 0; i < 10 && !ps_en; i++) @(negedge clk);
    for (int i = 0; i < 200 && !err_timeout; i++) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 64);
    check("tmo_cur", int'(cur_steps), 249);
    check("tmo_busy", int'(busy), 0);
    pulse_clr();
    check("tmo_clr", int'(err_timeout), 0);
    silent = 1'b0;

    // Stray PSDONE while idle.
    @(posedge clk);
    #1 force_done = 1'b1;
    @(posedge clk);
    #1 force_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_cur", int'(cur_steps), 249);

    // Lock loss mid-move at cur 10.
    do_move(10);
    send(30, 1'b0);
    mmcm_locked = 1'b0;
    @(negedge clk);
    check("lock_cur", int'(cur_steps), 0);
    check("lock_err", int'(err_lock), 1);
    check("lock_busy", int'(busy), 0);
    check("lock_ready", int'(req_if.req_ready), 0);
    repeat (5) @(negedge clk);
    mmcm_locked = 1'b1;
    m_cur = 0;
    pulse_clr();
    check("lock_clr", int'(err_lock), 0);
    mmcm_locked = 1'b0;
    repeat (2) @(negedge clk);
    check("lock_idle_zero", int'(err_lock), 0);
    mmcm_locked = 1'b1;
    do_move(3);
    mmcm_locked = 1'b0;
    repeat (2) @(negedge clk);
    check("lock_idle_nonzero", int'(err_lock), 1);
    check("lock_idle_cur", int'(cur_steps), 0);
    mmcm_locked = 1'b1;
    m_cur = 0;
    pulse_clr();

    // Reset mid-move.
    do_move(3);
    ps_delay = 12;
    push_ev(1'b0, 1'b1, 3);
    send(20, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_cur", int'(cur_steps), 0);
    check("mrst_outs", int'({ps_en, ps_incdec, done_pulse, busy}), 0);
    check("mrst_errs", int'({err_timeout, err_range, err_lock}), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mrst_after_cur", int'(cur_steps), 0);
    check("leftover_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
